// File: rtl/rst_seq.sv
// Reset sequencer: merges power-on, debounced button and software reset requests,
// then releases NumOut active-low reset domains in a fixed staggered order.
module rst_seq #(
    parameter int unsigned NumOut         = 3,
    parameter int unsigned HoldCycles     = 200,
    parameter int unsigned StaggerCycles  = 16,
    parameter int unsigned DebounceCycles = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ext_rst_ni,
    input  logic              sw_rst_req_i,
    output logic [NumOut-1:0] rst_no,
    output logic              rst_done_o,
    output logic [1:0]        rst_cause_o
);

    localparam int unsigned DebW  = $clog2(DebounceCycles + 1);
    localparam int unsigned HoldW = $clog2(HoldCycles + 1);
    localparam int unsigned StagW = $clog2(StaggerCycles + 1);
    localparam int unsigned IdxW  = $clog2(NumOut + 1);

    localparam logic [DebW-1:0]  DebMax  = DebW'(DebounceCycles);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles);
    localparam logic [StagW-1:0] StagMax = StagW'(StaggerCycles);
    localparam logic [IdxW-1:0]  IdxLast = IdxW'(NumOut - 1);

    localparam logic [1:0] CauseExt = 2'd1;
    localparam logic [1:0] CauseSw  = 2'd2;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    logic [1:0]        sync_q;
    logic              ext_sync;
    logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
    logic              ext_ok_q, ext_ok_d;

    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [StagW-1:0]  stag_q, stag_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [NumOut-1:0] rst_q, rst_d;
    logic              done_q, done_d;
    logic [1:0]        cause_q, cause_d;

    assign ext_sync = sync_q[1];

    // Two-flop synchroniser for the asynchronous reset button.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], ext_rst_ni};
        end
    end

    // Debounce: a low sample clears at once; release needs DebounceCycles high samples.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        ext_ok_d  = ext_ok_q;
        if (!ext_sync) begin
            deb_cnt_d = '0;
            ext_ok_d  = 1'b0;
        end else begin
            if (deb_cnt_q != DebMax) begin
                deb_cnt_d = deb_cnt_q + DebW'(1);
            end else begin
                deb_cnt_d = deb_cnt_q;
            end
            ext_ok_d = (deb_cnt_d == DebMax);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_cnt_q <= '0;
            ext_ok_q  <= 1'b0;
        end else begin
            deb_cnt_q <= deb_cnt_d;
            ext_ok_q  <= ext_ok_d;
        end
    end

    // Sequencer next-state and output logic.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        cause_d = cause_q;

        case (state_q)
            StHold: begin
                rst_d  = '0;
                done_d = 1'b0;
                stag_d = '0;
                if (!ext_ok_q || !ext_sync) begin
                    hold_d = '0;
                end else begin
                    if (hold_q != HoldMax) begin
                        hold_d = hold_q + HoldW'(1);
                    end else begin
                        hold_d = hold_q;
                    end
                    if (hold_d == HoldMax) begin
                        rst_d[0] = 1'b1;
                        idx_d    = IdxW'(1);
                        if (NumOut == 1) begin
                            done_d  = 1'b1;
                            state_d = StRun;
                        end else begin
                            state_d = StRelease;
                        end
                    end else begin
                        state_d = StHold;
                    end
                end
            end

            StRelease: begin
                if (!ext_sync) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    hold_d  = '0;
                    stag_d  = '0;
                    idx_d   = '0;
                    cause_d = CauseExt;
                    state_d = StHold;
                end else begin
                    if (stag_q != StagMax) begin
                        stag_d = stag_q + StagW'(1);
                    end else begin
                        stag_d = stag_q;
                    end
                    if (stag_d == StagMax) begin
                        stag_d = '0;
                        idx_d  = idx_q + IdxW'(1);
                        for (int i = 0; i < NumOut; i++) begin
                            if (idx_q == IdxW'(i)) begin
                                rst_d[i] = 1'b1;
                            end else begin
                                rst_d[i] = rst_q[i];
                            end
                        end
                        if (idx_q == IdxLast) begin
                            done_d  = 1'b1;
                            state_d = StRun;
                        end else begin
                            state_d = StRelease;
                        end
                    end else begin
                        state_d = StRelease;
                    end
                end
            end

            StRun: begin
                if (!ext_sync || sw_rst_req_i) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    hold_d  = '0;
                    stag_d  = '0;
                    idx_d   = '0;
                    // The button takes priority when both arrive together.
                    cause_d = (!ext_sync) ? CauseExt : CauseSw;
                    state_d = StHold;
                end else begin
                    state_d = StRun;
                end
            end

            default: begin
                rst_d   = '0;
                done_d  = 1'b0;
                hold_d  = '0;
                stag_d  = '0;
                idx_d   = '0;
                state_d = StHold;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StHold;
            hold_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    assign rst_no      = rst_q;
    assign rst_done_o  = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq with NumOut=3, Hold=8, Stagger=4, Debounce=4.
module tb_rst_seq;

    logic       clk;
    logic       rst_ni;
    logic       ext_rst_ni;
    logic       sw_rst_req_i;
    logic [2:0] rst_no;
    logic       rst_done_o;
    logic [1:0] rst_cause_o;

    int n_pass  = 0;
    int n_total = 0;

    rst_seq #(
        .NumOut         (3),
        .HoldCycles     (8),
        .StaggerCycles  (4),
        .DebounceCycles (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .ext_rst_ni   (ext_rst_ni),
        .sw_rst_req_i (sw_rst_req_i),
        .rst_no       (rst_no),
        .rst_done_o   (rst_done_o),
        .rst_cause_o  (rst_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ext;
        logic       sw;
        int         ncyc;
        logic [2:0] exp_rst;
        logic       exp_done;
        logic [1:0] exp_cause;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [2:0] r, input logic d, input logic [1:0] c);
        chk({nm, ".rst_no"}, 32'(rst_no), 32'(r));
        chk({nm, ".done"}, 32'(rst_done_o), 32'(d));
        chk({nm, ".cause"}, 32'(rst_cause_o), 32'(c));
    endtask

    // ext_rst_ni is high before edge 1: rst_no[0] at 14, [1] at 18, [2] and done at 22.
    task automatic por_seq(input string nm, input logic [1:0] cause);
        logic [2:0] er;
        for (int e = 1; e <= 24; e++) begin
            tick(1);
            er = {(e >= 22) ? 1'b1 : 1'b0, (e >= 18) ? 1'b1 : 1'b0, (e >= 14) ? 1'b1 : 1'b0};
            chk_all($sformatf("%s.e%0d", nm, e), er, (e >= 22) ? 1'b1 : 1'b0, cause);
        end
    endtask

    initial begin
        //            ext   sw    n    rst     done  cause
        vecs[0]  = '{1'b1, 1'b0, 13, 3'b000, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0,  1, 3'b001, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0,  3, 3'b001, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0,  1, 3'b011, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b0,  3, 3'b011, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b0,  1, 3'b111, 1'b1, 2'd0};
        vecs[6]  = '{1'b1, 1'b0,  5, 3'b111, 1'b1, 2'd0};
        vecs[7]  = '{1'b0, 1'b0,  2, 3'b111, 1'b1, 2'd0};
        vecs[8]  = '{1'b0, 1'b0,  1, 3'b000, 1'b0, 2'd1};
        vecs[9]  = '{1'b1, 1'b0, 13, 3'b000, 1'b0, 2'd1};
        vecs[10] = '{1'b1, 1'b0,  1, 3'b001, 1'b0, 2'd1};
        vecs[11] = '{1'b1, 1'b0,  8, 3'b111, 1'b1, 2'd1};
        vecs[12] = '{1'b1, 1'b0,  3, 3'b111, 1'b1, 2'd1};
        vecs[13] = '{1'b1, 1'b1,  1, 3'b000, 1'b0, 2'd2};
        vecs[14] = '{1'b1, 1'b0,  7, 3'b000, 1'b0, 2'd2};
        vecs[15] = '{1'b1, 1'b0,  1, 3'b001, 1'b0, 2'd2};
        vecs[16] = '{1'b1, 1'b0,  8, 3'b111, 1'b1, 2'd2};
        vecs[17] = '{1'b1, 1'b0,  2, 3'b111, 1'b1, 2'd2};
        vecs[18] = '{1'b0, 1'b0,  2, 3'b111, 1'b1, 2'd2};
        vecs[19] = '{1'b0, 1'b1,  1, 3'b000, 1'b0, 2'd1};
        vecs[20] = '{1'b1, 1'b0, 13, 3'b000, 1'b0, 2'd1};
        vecs[21] = '{1'b1, 1'b0,  1, 3'b001, 1'b0, 2'd1};
        vecs[22] = '{1'b1, 1'b1,  1, 3'b001, 1'b0, 2'd1};
        vecs[23] = '{1'b1, 1'b0,  2, 3'b001, 1'b0, 2'd1};
        vecs[24] = '{1'b1, 1'b0,  1, 3'b011, 1'b0, 2'd1};
        vecs[25] = '{1'b1, 1'b0,  4, 3'b111, 1'b1, 2'd1};

        rst_ni       = 1'b0;
        ext_rst_ni   = 1'b1;
        sw_rst_req_i = 1'b0;
        tick(2);
        chk_all("reset", 3'b000, 1'b0, 2'd0);

        // POR, button press, software reset, simultaneous events, ignored request.
        rst_ni = 1'b1;
        for (int i = 0; i < 26; i++) begin
            ext_rst_ni   = vecs[i].ext;
            sw_rst_req_i = vecs[i].sw;
            tick(vecs[i].ncyc);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_done, vecs[i].exp_cause);
        end

        // Button bounce: high 3 / low 1 five times must never release anything.
        ext_rst_ni = 1'b0;
        tick(3);
        chk_all("bounce.enter", 3'b000, 1'b0, 2'd1);
        for (int k = 0; k < 5; k++) begin
            ext_rst_ni = 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                chk($sformatf("bounce.hi%0d_%0d", k, j), 32'(rst_no), 32'd0);
            end
            ext_rst_ni = 1'b0;
            tick(1);
            chk($sformatf("bounce.lo%0d", k), 32'(rst_no), 32'd0);
        end
        ext_rst_ni = 1'b1;
        por_seq("bounce.rel", 2'd1);

        // Global reset during RELEASE clears everything asynchronously.
        sw_rst_req_i = 1'b1;
        tick(1);
        sw_rst_req_i = 1'b0;
        chk_all("t6.sw", 3'b000, 1'b0, 2'd2);
        tick(8);
        chk_all("t6.release0", 3'b001, 1'b0, 2'd2);
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk_all("t6.async", 3'b000, 1'b0, 2'd0);
        tick(1);
        rst_ni = 1'b1;
        por_seq("t6.por", 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
